set_assoc_wb_cache: RTL and testbench



---
 rtl/set_assoc_wb_cache.sv | 202 ++++++++++++++++++++
 tb/tb_set_assoc_wb_cache.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_wb_cache.sv
// N-way set-associative write-back cache with true-LRU replacement.
// Dirty victims are written back and read misses are refilled over a line-wide memory handshake.
module set_assoc_wb_cache #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_BITS  = 512,
  parameter int unsigned NUM_SETS   = 128,
  parameter int unsigned WAYS       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bgn,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [LINE_BITS-1:0]  data_to_write,
  output logic [LINE_BITS-1:0]  read_data,
  output logic                  hit,
  output logic                  miss,
  output logic                  done,
  output logic                  busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_BITS-1:0]  mem_wdata,
  input  logic                  mem_ack,
  input  logic [LINE_BITS-1:0]  mem_rdata,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);
  localparam int unsigned OB = $clog2(LINE_BITS / 8);
  localparam int unsigned IB = $clog2(NUM_SETS);
  localparam int unsigned AW = $clog2(WAYS);
  localparam int unsigned TB = ADDR_WIDTH - OB - IB;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, INSTALL} state_t;
  state_t state;

  logic [LINE_BITS-1:0] data_mem  [NUM_SETS][WAYS];
  logic [TB-1:0]        tag_mem   [NUM_SETS][WAYS];
  logic [WAYS-1:0]      valid_mem [NUM_SETS];
  logic [WAYS-1:0]      dirty_mem [NUM_SETS];
  logic [AW-1:0]        age_mem   [NUM_SETS][WAYS];

  logic                 op_write;
  logic [TB-1:0]        tag_q;
  logic [IB-1:0]        idx_q;
  logic [LINE_BITS-1:0] wdata_q;
  logic [LINE_BITS-1:0] fill_q;
  logic [AW-1:0]        victim_q;

  logic          lookup_hit;
  logic          have_invalid;
  logic [AW-1:0] hit_way;
  logic [AW-1:0] victim_way;
  logic [AW-1:0] lru_way;
  logic          unused_offset;

  assign unused_offset = ^address[OB-1:0];
  assign lru_way = (state == INSTALL) ? victim_q : hit_way;

  always_comb begin
    lookup_hit   = 1'b0;
    have_invalid = 1'b0;
    hit_way      = '0;
    victim_way   = '0;
    for (int unsigned j = 0; j < WAYS; j++) begin
      if (valid_mem[idx_q][j] && (tag_mem[idx_q][j] == tag_q) && !lookup_hit) begin
        lookup_hit = 1'b1;
        hit_way    = AW'(j);
      end
      if (!valid_mem[idx_q][j] && !have_invalid) begin
        have_invalid = 1'b1;
        victim_way   = AW'(j);
      end
    end
    // With every way valid the oldest line (age WAYS-1) is evicted.
    if (!have_invalid) begin
      for (int unsigned j = 0; j < WAYS; j++) begin
        if (age_mem[idx_q][j] == AW'(WAYS - 1)) victim_way = AW'(j);
      end
    end
  end

  // Line payload and tags are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (state == LOOKUP && lookup_hit && op_write)
      data_mem[idx_q][hit_way] <= wdata_q;
    if (state == INSTALL) begin
      data_mem[idx_q][victim_q] <= op_write ? wdata_q : fill_q;
      tag_mem[idx_q][victim_q]  <= tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_write   <= 1'b0;
      tag_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      fill_q     <= '0;
      victim_q   <= '0;
      read_data  <= '0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        for (int unsigned j = 0; j < WAYS; j++) age_mem[s][j] <= AW'(j);
      end
    end else begin
      done <= 1'b0;
      hit  <= 1'b0;
      miss <= 1'b0;

      if ((state == LOOKUP && lookup_hit) || state == INSTALL) begin
        for (int unsigned j = 0; j < WAYS; j++) begin
          if (AW'(j) == lru_way)
            age_mem[idx_q][j] <= '0;
          else if (age_mem[idx_q][j] < age_mem[idx_q][lru_way])
            age_mem[idx_q][j] <= age_mem[idx_q][j] + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (bgn && (read || write)) begin
            op_write <= write;
            tag_q    <= address[ADDR_WIDTH-1 -: TB];
            idx_q    <= address[OB +: IB];
            wdata_q  <= data_to_write;
            busy     <= 1'b1;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lookup_hit) begin
            if (op_write) dirty_mem[idx_q][hit_way] <= 1'b1;
            else          read_data <= data_mem[idx_q][hit_way];
            done <= 1'b1;
            hit  <= 1'b1;
            if (hit_count != '1) hit_count <= hit_count + 1'b1;
            state <= IDLE;
          end else begin
            victim_q <= victim_way;
            if (valid_mem[idx_q][victim_way] && dirty_mem[idx_q][victim_way]) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {tag_mem[idx_q][victim_way], idx_q, {OB{1'b0}}};
              mem_wdata <= data_mem[idx_q][victim_way];
              state     <= WRITEBACK;
            end else if (op_write) begin
              state <= INSTALL;
            end else begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {tag_q, idx_q, {OB{1'b0}}};
              state    <= REFILL;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= op_write ? INSTALL : REFILL;
          end
        end
        REFILL: begin
          // Entered with mem_req low after a write-back: that idle cycle separates the phases.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {tag_q, idx_q, {OB{1'b0}}};
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            fill_q  <= mem_rdata;
            state   <= INSTALL;
          end
        end
        INSTALL: begin
          valid_mem[idx_q][victim_q] <= 1'b1;
          dirty_mem[idx_q][victim_q] <= op_write;
          if (!op_write) read_data <= fill_q;
          done <= 1'b1;
          miss <= 1'b1;
          if (miss_count != '1) miss_count <= miss_count + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_set_assoc_wb_cache.sv
// Directed bench for set_assoc_wb_cache: table of requests with a responding memory,
// plus hand sequences for a stalled refill with mid-transaction reset and counter saturation.
module tb_set_assoc_wb_cache;
  localparam int unsigned LB = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bgn = 1'b0, read = 1'b0, write = 1'b0;
  logic [31:0]   address = '0;
  logic [LB-1:0] data_to_write = '0;
  logic [LB-1:0] read_data;
  logic          hit, miss, done, busy;
  logic          mem_req, mem_we;
  logic [31:0]   mem_addr;
  logic [LB-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [LB-1:0] mem_rdata = '0;
  logic [31:0]   hit_count, miss_count;

  always #5 clk = ~clk;

  set_assoc_wb_cache #(.ADDR_WIDTH(32), .LINE_BITS(LB), .NUM_SETS(128), .WAYS(4)) dut (
    .clk(clk), .rst_n(rst_n), .bgn(bgn), .read(read), .write(write),
    .address(address), .data_to_write(data_to_write), .read_data(read_data),
    .hit(hit), .miss(miss), .done(done), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct {
    bit          rst;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] fill;
    bit          exp_hit;
    bit          exp_wb;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    bit          exp_rf;
    logic [31:0] rf_addr;
    logic [31:0] exp_rd;
    logic [31:0] exp_hc;
    logic [31:0] exp_mc;
  } vec_t;

  vec_t tv [19];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bgn = 1'b0; read = 1'b0; write = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", LB'(mem_req), '0);
    chk("rst_busy", LB'(busy), '0);
    chk("rst_done", LB'({done, hit, miss}), '0);
    chk("rst_read_data", read_data, '0);
    chk("rst_counts", LB'({hit_count, miss_count}), '0);
    rst_n = 1'b1;
  endtask

  task automatic do_req(input vec_t v, input int n);
    logic          got_done = 1'b0, gh = 1'b0, gm = 1'b0;
    logic [LB-1:0] grd = '0, wbd = '0;
    logic [31:0]   wba = '0, rfa = '0, prev_addr = '0;
    logic          swb = 1'b0, srf = 1'b0, unstable = 1'b0, nb = 1'b0;
    logic          prev_req = 1'b0, prev_we = 1'b0;
    int            dc = -1, wc = 0;
    @(negedge clk);
    chk($sformatf("v%0d idle_busy", n), LB'(busy), '0);
    bgn = 1'b1; read = !v.wr; write = v.wr; address = v.addr; data_to_write = LB'(v.wdata);
    @(negedge clk);
    bgn = 1'b0; read = 1'b0; write = 1'b0;
    for (int c = 0; c < 60 && !got_done; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!busy) nb = 1'b1;
      if (mem_req && prev_req && (mem_we != prev_we || mem_addr != prev_addr)) unstable = 1'b1;
      prev_req = mem_req; prev_we = mem_we; prev_addr = mem_addr;
      if (done) begin
        got_done = 1'b1; dc = c; gh = hit; gm = miss; grd = read_data;
      end else if (mem_req) begin
        if (mem_we) begin swb = 1'b1; wba = mem_addr; wbd = mem_wdata; end
        else begin srf = 1'b1; rfa = mem_addr; end
        if (wc >= v.delay) begin mem_ack = 1'b1; mem_rdata = LB'(v.fill); wc = 0; end
        else wc++;
      end
    end
    chk($sformatf("v%0d done", n), LB'(got_done), LB'(1'b1));
    chk($sformatf("v%0d hit_miss", n), LB'({gh, gm}), LB'({v.exp_hit, !v.exp_hit}));
    chk($sformatf("v%0d busy_held", n), LB'(nb), '0);
    chk($sformatf("v%0d mem_stable", n), LB'(unstable), '0);
    chk($sformatf("v%0d writeback_seen", n), LB'(swb), LB'(v.exp_wb));
    chk($sformatf("v%0d refill_seen", n), LB'(srf), LB'(v.exp_rf));
    if (v.exp_wb) begin
      chk($sformatf("v%0d wb_addr", n), LB'(wba), LB'(v.wb_addr));
      chk($sformatf("v%0d wb_data", n), wbd, LB'(v.wb_data));
    end
    if (v.exp_rf) chk($sformatf("v%0d rf_addr", n), LB'(rfa), LB'(v.rf_addr));
    if (!v.wr) chk($sformatf("v%0d read_data", n), grd, LB'(v.exp_rd));
    if (v.exp_hit) chk($sformatf("v%0d hit_latency", n), LB'(dc), '0);
    chk($sformatf("v%0d hit_count", n), LB'(hit_count), LB'(v.exp_hc));
    chk($sformatf("v%0d miss_count", n), LB'(miss_count), LB'(v.exp_mc));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t sv;
    logic [31:0] req_addr;
    int w;
    // rst wr addr wdata dly fill | hit wb wb_addr wb_data rf rf_addr rd hc mc
    tv[0]  = '{1'b1, 1'b0, 32'h2000, 32'h0,  0, 32'hAA, 1'b0, 1'b0, 32'h0,    32'h0, 1'b1, 32'h2000, 32'hAA, 32'd0, 32'd1};
    tv[1]  = '{1'b0, 1'b1, 32'h2000, 32'h11, 0, 32'h0,  1'b1, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,    32'h0,  32'd1, 32'd1};
    tv[2]  = '{1'b0, 1'b0, 32'h2000, 32'h0,  0, 32'h0,  1'b1, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,    32'h11, 32'd2, 32'd1};
    tv[3]  = '{1'b0, 1'b1, 32'h2000, 32'h1,  0, 32'h0,  1'b1, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,    32'h0,  32'd3, 32'd1};
    tv[4]  = '{1'b0, 1'b1, 32'h4000, 32'h2,  0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,    32'h0,  32'd3, 32'd2};
    tv[5]  = '{1'b0, 1'b1, 32'h6000, 32'h3,  0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,    32'h0,  32'd3, 32'd3};
    tv[6]  = '{1'b0, 1'b1, 32'h8000, 32'h4,  0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,    32'h0,  32'd3, 32'd4};
    tv[7]  = '{1'b0, 1'b1, 32'hA000, 32'h5,  0, 32'h0,  1'b0, 1'b1, 32'h2000, 32'h1, 1'b0, 32'h0,    32'h0,  32'd3, 32'd5};
    tv[8]  = '{1'b0, 1'b0, 32'h4000, 32'h0,  0, 32'h0,  1'b1, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,    32'h2,  32'd4, 32'd5};
    tv[9]  = '{1'b0, 1'b0, 32'h007F, 32'h0,  3, 32'h77, 1'b0, 1'b0, 32'h0,    32'h0, 1'b1, 32'h0040, 32'h77, 32'd4, 32'd6};
    tv[10] = '{1'b0, 1'b0, 32'h0040, 32'h0,  0, 32'h0,  1'b1, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,    32'h77, 32'd5, 32'd6};
    tv[11] = '{1'b1, 1'b1, 32'h2000, 32'h1,  0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,    32'h0,  32'd0, 32'd1};
    tv[12] = '{1'b0, 1'b1, 32'h4000, 32'h2,  0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,    32'h0,  32'd0, 32'd2};
    tv[13] = '{1'b0, 1'b1, 32'h6000, 32'h3,  0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,    32'h0,  32'd0, 32'd3};
    tv[14] = '{1'b0, 1'b1, 32'h8000, 32'h4,  0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,    32'h0,  32'd0, 32'd4};
    tv[15] = '{1'b0, 1'b0, 32'h2000, 32'h0,  0, 32'h0,  1'b1, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,    32'h1,  32'd1, 32'd4};
    tv[16] = '{1'b0, 1'b0, 32'h4000, 32'h0,  0, 32'h0,  1'b1, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,    32'h2,  32'd2, 32'd4};
    tv[17] = '{1'b0, 1'b0, 32'hA000, 32'h0,  1, 32'h55, 1'b0, 1'b1, 32'h6000, 32'h3, 1'b1, 32'hA000, 32'h55, 32'd2, 32'd5};
    tv[18] = '{1'b0, 1'b0, 32'h6000, 32'h0,  0, 32'h33, 1'b0, 1'b1, 32'h8000, 32'h4, 1'b1, 32'h6000, 32'h33, 32'd2, 32'd6};

    for (int i = 0; i < 19; i++) begin
      if (tv[i].rst) do_reset();
      do_req(tv[i], i);
    end

    // Stalled refill with a dropped request, then reset mid-refill.
    do_reset();
    @(negedge clk);
    bgn = 1'b1; read = 1'b1; address = 32'hC000;
    @(negedge clk);
    bgn = 1'b0; read = 1'b0;
    w = 0;
    while (!mem_req && w < 10) begin @(negedge clk); w++; end
    chk("stall_req_rise", LB'(mem_req), LB'(1'b1));
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin bgn = 1'b1; write = 1'b1; address = 32'h4000; data_to_write = LB'(32'hEE); end
      if (c == 4) begin bgn = 1'b0; write = 1'b0; end
      chk($sformatf("stall_c%0d req_we_busy", c), LB'({mem_req, mem_we, busy}), LB'(3'b101));
      chk($sformatf("stall_c%0d addr", c), LB'(mem_addr), LB'(32'hC000));
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req", LB'(mem_req), '0);
    chk("async_rst_busy_done", LB'({busy, done}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    sv = '{1'b0, 1'b0, 32'hC000, 32'h0, 0, 32'hCC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hC000, 32'hCC, 32'd0, 32'd1};
    do_req(sv, 100);

    // Hit counter saturation.
    do_reset();
    sv = '{1'b0, 1'b0, 32'h2000, 32'h0, 0, 32'h99, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h2000, 32'h99, 32'd0, 32'd1};
    do_req(sv, 101);
    #1 force dut.hit_count = 32'hFFFF_FFFE;
    #1 release dut.hit_count;
    chk("sat_preload", LB'(hit_count), LB'(32'hFFFF_FFFE));
    sv = '{1'b0, 1'b0, 32'h2000, 32'h0, 0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h99, 32'hFFFF_FFFF, 32'd1};
    for (int k = 0; k < 3; k++) do_req(sv, 102 + k);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
